// File: rtl/lsu_wb_stage_pkg.sv
// Shared types and constants for the load/store + writeback stage.
package lsu_wb_stage_pkg;

  localparam int unsigned DEF_REGS_DIG = 4;
  localparam int unsigned DEF_XLEN     = 32;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StWb
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] EXC_NONE     = 2'd0;
  localparam logic [1:0] EXC_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_BUS      = 2'd2;

  // Size code 3 is reserved and always faults when used for a memory access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane/strobe generation and load extract/extend for a 32-bit word port.
module lsu_align
  import lsu_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = DEF_XLEN
) (
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    wdata = store_data;
    wstrb = 4'hF;
    case (size)
      SZ_B: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      SZ_H: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << addr_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    load_data = rdata;
    case (size)
      SZ_B: load_data = {{(XLEN-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_H: load_data = {{(XLEN-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_wb_stage.sv
// Memory-access and writeback stage: one instruction at a time, optional
// load/store over a req/resp port, then a single-cycle register-file write.
module lsu_wb_stage
  import lsu_wb_stage_pkg::*;
#(
  parameter int unsigned REGS_DIG = DEF_REGS_DIG,
  parameter int unsigned XLEN     = DEF_XLEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exu_valid,
  output logic                exu_ready,
  input  logic [XLEN-1:0]     exu_alu_result,
  input  logic [XLEN-1:0]     exu_store_data,
  input  logic [REGS_DIG-1:0] exu_rd,
  input  logic                exu_reg_write,
  input  logic                exu_mem_ren,
  input  logic                exu_mem_wen,
  input  logic [1:0]          exu_mem_size,
  input  logic                exu_mem_unsigned,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [XLEN-1:0]     mem_addr,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic                mem_resp_valid,
  input  logic [XLEN-1:0]     mem_resp_rdata,
  input  logic                mem_resp_err,
  output logic [REGS_DIG-1:0] wb_rd,
  output logic                wb_reg_write,
  output logic [XLEN-1:0]     wb_result,
  output logic                wb_retire,
  output logic [1:0]          wb_exc
);

  lsu_state_e state_q, state_d;

  logic [XLEN-1:0]     addr_q, sdata_q, load_q;
  logic [REGS_DIG-1:0] rd_q;
  logic                reg_write_q, ren_q, wen_q, unsigned_q;
  logic [1:0]          size_q, exc_q;

  logic            mem_access, misalign, accept, resp_take;
  logic [XLEN-1:0] align_wdata, align_load;
  logic [3:0]      align_wstrb;

  assign mem_access = exu_mem_ren | exu_mem_wen;
  assign misalign   = mem_access & is_misaligned(exu_mem_size, exu_alu_result[1:0]);
  assign accept     = (state_q == StIdle) & exu_valid;
  assign resp_take  = (state_q == StWait) & mem_resp_valid;

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .store_data  (sdata_q),
    .rdata       (mem_resp_rdata),
    .wdata       (align_wdata),
    .wstrb       (align_wstrb),
    .load_data   (align_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      sdata_q     <= '0;
      load_q      <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      ren_q       <= 1'b0;
      wen_q       <= 1'b0;
      unsigned_q  <= 1'b0;
      size_q      <= 2'b00;
      exc_q       <= EXC_NONE;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q      <= exu_alu_result;
        sdata_q     <= exu_store_data;
        load_q      <= '0;
        rd_q        <= exu_rd;
        reg_write_q <= exu_reg_write;
        ren_q       <= exu_mem_ren;
        wen_q       <= exu_mem_wen;
        unsigned_q  <= exu_mem_unsigned;
        size_q      <= exu_mem_size;
        exc_q       <= misalign ? EXC_MISALIGN : EXC_NONE;
      end
      // Faulted loads keep the cleared load value rather than bus garbage.
      if (resp_take) begin
        if (mem_resp_err) begin
          exc_q <= EXC_BUS;
        end else begin
          load_q <= align_load;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    exu_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    mem_wstrb     = 4'h0;
    wb_rd         = '0;
    wb_reg_write  = 1'b0;
    wb_result     = '0;
    wb_retire     = 1'b0;
    wb_exc        = EXC_NONE;
    unique case (state_q)
      StIdle: begin
        exu_ready = 1'b1;
        if (exu_valid) begin
          state_d = (mem_access && !misalign) ? StReq : StWb;
        end
      end
      StReq: begin
        mem_req_valid = 1'b1;
        mem_addr      = {addr_q[XLEN-1:2], 2'b00};
        mem_we        = wen_q;
        mem_wdata     = align_wdata;
        mem_wstrb     = align_wstrb;
        if (mem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_resp_valid) begin
          state_d = StWb;
        end
      end
      StWb: begin
        wb_retire    = 1'b1;
        wb_rd        = rd_q;
        wb_result    = ren_q ? load_q : addr_q;
        wb_exc       = exc_q;
        wb_reg_write = reg_write_q & ~wen_q & (exc_q == EXC_NONE) & (rd_q != '0);
        state_d      = StIdle;
      end
    endcase
  end

endmodule
